// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Single-entry holding register for the fetched word and its PC.
// Revision : 1.0
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc
);

    logic            valid_q, valid_d;
    logic [31:0]     data_q,  data_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    // Clearing only drops validity; the stored word is kept until the next load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc_d    = pc_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_instr;
            pc_d    = load_pc;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_INSTR;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc_q    <= pc_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = valid_q ? data_q : NOP_INSTR;
    assign instr_pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC owner and single-outstanding instruction fetcher with redirect.
//            Optional macro FETCH_MISALIGN_TRAP_EN halts on a target with bit 1 set.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            misaligned
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            misaligned_q, misaligned_d;
    logic            req_valid_q, req_valid_d;

    logic            w_trap_fire;
    logic            w_redir_apply;
    logic [XLEN-1:0] w_target;
    logic            w_buf_load;
    logic            w_buf_clear;

    assign w_target = redirect_target & ~XLEN'(INSTR_BYTES - 1);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_trap_fire = redirect_valid && (state_q != ST_HALT) && redirect_target[1];
`else
    assign w_trap_fire = 1'b0;
`endif

    assign w_redir_apply = redirect_valid && (state_q != ST_HALT) && !w_trap_fire;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        misaligned_d = misaligned_q;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;

        if (w_trap_fire) begin
            state_d      = ST_HALT;
            misaligned_d = 1'b1;
            w_buf_clear  = (state_q == ST_HOLD);
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_REQ;
                    if (w_redir_apply) pc_d = w_target;
                end
                ST_REQ: begin
                    if (imem_req_ready) state_d = ST_WAIT;
                    // An accepted request whose address was just redirected is stale.
                    if (w_redir_apply) begin
                        pc_d = w_target;
                        if (imem_req_ready) kill_d = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_redir_apply) begin
                        pc_d = w_target;
                        if (imem_rsp_valid) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            w_buf_load = 1'b1;
                            pc_d       = pc_q + XLEN'(INSTR_BYTES);
                            state_d    = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_redir_apply) begin
                        pc_d        = w_target;
                        w_buf_clear = 1'b1;
                        state_d     = ST_REQ;
                    end else if (instr_ready) begin
                        w_buf_clear = 1'b1;
                        state_d     = ST_REQ;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end

        req_valid_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            misaligned_q <= 1'b0;
            req_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            misaligned_q <= misaligned_d;
            req_valid_q  <= req_valid_d;
        end
    end

    fetch_buffer #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_buf_load),
        .clear      (w_buf_clear),
        .load_instr (imem_rsp_data),
        .load_pc    (pc_q),
        .valid      (instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign misaligned     = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        instr_valid, instr_ready, redirect_valid, misaligned;
    logic [31:0] instr, instr_pc, redirect_target;

    logic        w_req_valid, w_instr_valid, w_misaligned;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;

    int checks = 0;
    int errors = 0;

    logic        pend;
    logic [31:0] pend_addr;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned      (misaligned)
    );

    // Second instance shares all inputs; only its address sequence is checked.
    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (w_req_valid),
        .imem_req_addr   (w_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (w_instr_valid),
        .instr           (w_instr),
        .instr_pc        (w_instr_pc),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misaligned      (w_misaligned)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of memory/decode stimulus; memory answers one cycle after acceptance
    // unless rsp_en holds the response back.
    task automatic cycle(input logic mem_rdy, input logic rsp_en, input logic ir,
                         input logic rv, input logic [31:0] rt);
        imem_req_ready  = mem_rdy;
        imem_rsp_valid  = pend && rsp_en;
        imem_rsp_data   = word_of(pend_addr);
        instr_ready     = ir;
        redirect_valid  = rv;
        redirect_target = rt;
        #1;
        if (imem_rsp_valid) pend = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        pend = 1'b0; pend_addr = '0;
        repeat (3) @(posedge clk);
        #1;

        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
        rst = 1'b0;

        // Streaming fetch: BOOT, then REQ/WAIT/HOLD repeating every 3 cycles.
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("seq_req_valid_c%0d", c), {31'd0, imem_req_valid}, {31'd0, (c % 3 == 1)});
            chk($sformatf("seq_instr_valid_c%0d", c), {31'd0, instr_valid}, {31'd0, (c % 3 == 0) && (c != 0)});
            if (c % 3 == 1) begin
                chk($sformatf("seq_addr_c%0d", c), imem_req_addr, 32'((c / 3) * 4));
                chk($sformatf("wrap_addr_c%0d", c), w_req_addr, 32'hFFFF_FFFC + 32'((c / 3) * 4));
            end
            if (c % 3 == 0 && c != 0) begin
                chk($sformatf("seq_pc_c%0d", c), instr_pc, 32'(((c / 3) - 1) * 4));
                chk($sformatf("seq_instr_c%0d", c), instr, word_of(32'(((c / 3) - 1) * 4)));
            end
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        end

        // Decode stall in HOLD for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, word_of(32'h8));
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("after_stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("after_stall_addr", imem_req_addr, 32'hC);
        chk("after_stall_instr_valid", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x100 while waiting; the late response for 0xC is dropped.
        chk("wait_instr_valid", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("kill_wait_req", {31'd0, imem_req_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("redir_addr", imem_req_addr, 32'h100);
        chk("redir_no_stale", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_valid", {31'd0, instr_valid}, 32'd1);
        chk("redir_pc", instr_pc, 32'h100);
        chk("redir_instr", instr, word_of(32'h100));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x40 in the same cycle the request for 0x104 is accepted.
        chk("req104_addr", imem_req_addr, 32'h104);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        chk("req_kill_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("req_kill_no_valid", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("req40_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req40_addr", imem_req_addr, 32'h40);
        chk("req40_no_stale", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wait40_no_stale", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold40_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold40_pc", instr_pc, 32'h40);
        chk("hold40_instr", instr, word_of(32'h40));

        // Redirect in HOLD to 0x81: low bits cleared, buffer discarded.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h81);
        chk("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("hold_redir_instr", instr, NOP);
        chk("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
        chk("hold_redir_addr", imem_req_addr, 32'h80);

        // Misaligned target 0x102 while REQ is stalled by the memory.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("mis_addr_kept", imem_req_addr, 32'h80);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_no_valid", {31'd0, instr_valid}, 32'd0);
            chk("halt_flag", {31'd0, misaligned}, 32'd1);
        end
`else
        chk("mis_flag", {31'd0, misaligned}, 32'd0);
        chk("mis_req", {31'd0, imem_req_valid}, 32'd1);
        chk("mis_addr", imem_req_addr, 32'h100);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mis_hold_pc", instr_pc, 32'h100);
        chk("mis_hold_valid", {31'd0, instr_valid}, 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
`endif

        // Asynchronous reset mid-flight, then a stray response during BOOT.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("arst_req_addr", imem_req_addr, 32'h0);
        chk("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_instr", instr, NOP);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_misaligned", {31'd0, misaligned}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        chk("boot_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("boot_req_addr", imem_req_addr, 32'h0);
        chk("boot_ignore_rsp", {31'd0, instr_valid}, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post_rst_valid", {31'd0, instr_valid}, 32'd1);
        chk("post_rst_pc", instr_pc, 32'h0);
        chk("post_rst_instr", instr, word_of(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
